weight_fetch_ctrl: RTL and testbench
====================================

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 28, number of weight words per bank (addresses 0..DEPTH-1).
REQ-002 Parameter AW, default 5, address width; DEPTH <= 2**AW SHALL hold.
REQ-003 Parameter DW, default 16, weight width; weights are signed two's complement.
REQ-004 CLK  in  1  single clock; all block logic SHALL be clocked on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 load_start  in  1  one-cycle request to begin a sequential bank write.
REQ-007 fetch_start  in  1  one-cycle request to begin a sequential bank read.
REQ-008 load_data  in  DW  weight word to write.
REQ-009 load_valid  in  1  load_data is valid.
REQ-010 load_ready  out  1  controller accepts load_data this cycle.
REQ-011 w_data  out  DW  signed weight to the MAC datapath.
REQ-012 w_valid  out  1  w_data is valid.
REQ-013 w_ready  in  1  MAC datapath accepts w_data.
REQ-014 w_last  out  1  w_data is the word at address DEPTH-1.
REQ-015 busy  out  1  state is not IDLE.
REQ-016 done  out  1  one-cycle pulse at the end of a load or fetch.
REQ-017 bram_addr  out  AW  weight BRAM address.
REQ-018 bram_di  out  DW  weight BRAM write data.
REQ-019 bram_en  out  1  weight BRAM enable.
REQ-020 bram_we  out  1  weight BRAM write enable.
REQ-021 bram_do  in  DW  weight BRAM read data; the BRAM registers it on the falling edge of a cycle with bram_en=1, bram_we=0.

Function
REQ-022 The FSM SHALL have the states IDLE, LOAD, FETCH and DONE.
REQ-023 IDLE: load_start -> LOAD; fetch_start -> FETCH; load_start SHALL win when both are asserted.
REQ-024 load_start and fetch_start SHALL be ignored outside IDLE.
REQ-025 LOAD: load_ready=1; a word SHALL be written only in cycles with load_valid=1, driving bram_en=1, bram_we=1, bram_di=load_data and bram_addr=the write pointer.
REQ-026 LOAD: the write pointer SHALL start at 0, increment per accepted word, and the FSM SHALL go to DONE after the word at DEPTH-1 is accepted.
REQ-027 FETCH: a read issue SHALL drive bram_en=1, bram_we=0 and bram_addr=the read pointer.
REQ-028 Read data SHALL be captured from bram_do on the rising edge that follows the issue cycle (read latency 1).
REQ-029 Captured words SHALL enter a 2-entry output FIFO whose head drives w_data and w_valid.
REQ-030 A read SHALL be issued only when the FIFO occupancy plus reads in flight is less than 2, so no word is ever dropped.
REQ-031 With w_ready held high, the block SHALL sustain one word per cycle after the 1-cycle fill latency.
REQ-032 w_data and w_last SHALL hold stable while w_valid=1 and w_ready=0.
REQ-033 w_last SHALL be 1 only with the word read from address DEPTH-1.
REQ-034 FETCH SHALL go to DONE in the cycle after the w_last word is accepted (w_valid & w_ready & w_last).
REQ-035 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-036 Pointers SHALL reset to 0 on entry to LOAD or FETCH and never exceed DEPTH-1; there is no wrap within an operation.
REQ-037 bram_en SHALL be 0 in IDLE and DONE, and in LOAD/FETCH cycles that perform no access.

Reset
REQ-038 While RST=1: the FSM SHALL go to IDLE, pointers and FIFO SHALL clear, and w_valid, w_last, load_ready, busy, done, bram_en, bram_we, bram_addr, bram_di and w_data SHALL be 0.
REQ-039 RST mid-LOAD or mid-FETCH SHALL abort the operation, discard any in-flight read, and not alter BRAM contents already written.

Structure
REQ-040 DEPTH, AW, DW and the FSM state encoding SHALL live in the shared ANN package.
REQ-041 The 2-entry output FIFO SHALL be one sub-module, weight_skid_fifo.

Verification
REQ-042 Load 0x0001..0x001C with load_valid=1 throughout -> 28 consecutive writes at addresses 0..27, done after the last write, busy=0 afterwards.
REQ-043 Fetch with w_ready=1 after that load -> w_data = 1..28 on 28 consecutive cycles, w_last only on 28 (0x001C), done one cycle later.
REQ-044 Fetch with w_ready toggling 1,0,0,1 -> no words lost or duplicated, w_data stable while stalled, bram_addr never more than 2 ahead of the accepted count.
REQ-045 load_start and fetch_start asserted together in IDLE -> LOAD entered; fetch_start pulsed during LOAD -> ignored.
REQ-046 RST asserted after 10 fetched words -> IDLE next cycle with all outputs 0; a new fetch restarts at address 0 and returns the loaded values.
REQ-047 Load of 0x8000 (most negative weight) at address 27 -> fetched w_data = 0x8000 with w_last=1.

Source files
------------

// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared ANN package: default weight-bank geometry and the weight fetch
// controller state encoding.
//   WF_DEPTH : weight words per bank (addresses 0..WF_DEPTH-1)
//   WF_AW    : BRAM address width, WF_DEPTH <= 2**WF_AW
//   WF_DW    : signed two's complement weight width
package weight_fetch_ctrl_pkg;

  localparam int WF_DEPTH = 28;
  localparam int WF_AW    = 5;
  localparam int WF_DW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } wf_state_e;

endpackage

// File: rtl/weight_fetch_ctrl_skid_fifo.sv
// weight_skid_fifo: 2-entry output FIFO between the BRAM read capture and
// the MAC weight stream. The head entry drives out_data/out_last and only
// changes on a pop, so the head holds stable while the consumer stalls.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   in_valid/in_data/in_last   push side (word captured from BRAM)
//   out_valid/out_data/out_last/out_ready   pop side (valid/ready)
//   count                 current occupancy 0..2
module weight_skid_fifo #(
  parameter int DW = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  logic signed [DW-1:0] data_q [2];
  logic                 last_q [2];
  logic                 wr_sel_q;
  logic                 rd_sel_q;
  logic [1:0]           cnt_q;
  logic                 push;
  logic                 pop;

  assign push      = in_valid && (cnt_q != 2'd2);
  assign pop       = out_valid && out_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = data_q[rd_sel_q];
  assign out_last  = last_q[rd_sel_q];
  assign count     = cnt_q;

  // Storage is cleared with the control state so that w_data reads 0
  // after a reset, not a stale weight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_sel_q] <= in_data;
        last_q[wr_sel_q] <= in_last;
        wr_sel_q         <= ~wr_sel_q;
      end
      if (pop) begin
        rd_sel_q <= ~rd_sel_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: loads a bank of DEPTH signed weights into a BRAM and
// streams them back out to the MAC datapath with valid/ready flow control.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   load_start, fetch_start     one-cycle operation requests (IDLE only)
//   load_data/load_valid/load_ready   write stream into the bank
//   w_data/w_valid/w_ready/w_last     weight stream to the MAC
//   busy, done                  status (done pulses for one cycle)
//   bram_addr/bram_di/bram_en/bram_we/bram_do   BRAM port; bram_do is
//                               registered by the BRAM on the falling edge
module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = WF_DEPTH,
  parameter int AW    = WF_AW,
  parameter int DW    = WF_DW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load_start,
  input  logic                 fetch_start,
  input  logic signed [DW-1:0] load_data,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic signed [DW-1:0] w_data,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic                 w_last,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        bram_addr,
  output logic signed [DW-1:0] bram_di,
  output logic                 bram_en,
  output logic                 bram_we,
  input  logic signed [DW-1:0] bram_do
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  wf_state_e            state_q;
  wf_state_e            state_d;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic                 rd_all_q;
  logic                 wr_en;
  logic                 rd_issue_p0;
  logic                 fifo_vld;
  logic                 fifo_last;
  logic signed [DW-1:0] fifo_data;
  logic [1:0]           fifo_cnt;

  assign wr_en = !RST && (state_q == ST_LOAD) && load_valid;

  // The BRAM returns data by the rising edge that closes the issue cycle,
  // so a read is only in flight during its own issue cycle and the FIFO
  // occupancy alone bounds how many reads may be outstanding.
  assign rd_issue_p0 = !RST && (state_q == ST_FETCH) && !rd_all_q &&
                       (fifo_cnt < 2'd2);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start)       state_d = ST_LOAD;
        else if (fetch_start) state_d = ST_FETCH;
      end
      ST_LOAD: begin
        if (load_valid && (wr_ptr_q == LAST_ADDR)) state_d = ST_DONE;
      end
      ST_FETCH: begin
        if (fifo_vld && w_ready && fifo_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; everything is forced to 0 while RST is high, including the
  // first reset cycle before the state register has returned to IDLE.
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_data     = '0;
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_di    = '0;
    if (!RST) begin
      load_ready = (state_q == ST_LOAD);
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_DONE);
      w_valid    = fifo_vld;
      w_last     = fifo_vld && fifo_last;
      w_data     = fifo_data;
      if (wr_en) begin
        bram_en   = 1'b1;
        bram_we   = 1'b1;
        bram_addr = wr_ptr_q;
        bram_di   = load_data;
      end else if (rd_issue_p0) begin
        bram_en   = 1'b1;
        bram_addr = rd_ptr_q;
      end
    end
  end

  // Pointers park at 0 in IDLE so every operation starts at address 0;
  // they stop at LAST_ADDR instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST || (state_q == ST_IDLE)) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_all_q <= 1'b0;
    end else begin
      if (wr_en && (wr_ptr_q != LAST_ADDR)) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_issue_p0) begin
        if (rd_ptr_q == LAST_ADDR) rd_all_q <= 1'b1;
        else                       rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Capture stage: bram_do is pushed on the edge that ends the issue cycle
  weight_skid_fifo #(
    .DW(DW)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (rd_issue_p0),
    .in_data   (bram_do),
    .in_last   (rd_ptr_q == LAST_ADDR),
    .out_valid (fifo_vld),
    .out_data  (fifo_data),
    .out_last  (fifo_last),
    .out_ready (w_ready),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl with a behavioural BRAM model.
module tb_weight_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        load_start, fetch_start, load_valid, w_ready;
  logic [15:0] load_data;
  logic [15:0] bram_do = '0;
  logic        load_ready, w_valid, w_last, busy, done, bram_en, bram_we;
  logic [15:0] w_data, bram_di;
  logic [4:0]  bram_addr;

  int          total = 0;
  int          bad = 0;
  logic [15:0] mem [32];
  logic [20:0] wq [$];
  logic [16:0] rq [$];
  int          acc_cnt = 0;
  logic        stall_q = 1'b0;
  logic [17:0] held = '0;
  logic [43:0] outs;

  always #5 CLK = ~CLK;

  assign outs = {w_valid, w_last, load_ready, busy, done, bram_en, bram_we,
                 bram_addr, bram_di, w_data};

  weight_fetch_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .load_start  (load_start),
    .fetch_start (fetch_start),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .w_data      (w_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_last      (w_last),
    .busy        (busy),
    .done        (done),
    .bram_addr   (bram_addr),
    .bram_di     (bram_di),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_do     (bram_do)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // BRAM model: writes and registered reads on the falling edge
  always @(negedge CLK) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_di;
      else         bram_do <= mem[bram_addr];
    end
  end

  // Write-side monitor
  always @(negedge CLK) begin
    if (bram_en && bram_we) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_write: got addr %0d data %h want no write", bram_addr, bram_di);
      end else begin
        chk("bram_write", {bram_addr, bram_di}, wq.pop_front());
      end
    end
  end

  // Read-side monitor
  always @(negedge CLK) begin
    if (!busy) acc_cnt = 0;
    if (stall_q) chk("stall_hold", {w_valid, w_last, w_data}, held);
    if (bram_en && !bram_we) chk("addr_ahead", int'(bram_addr) <= acc_cnt + 2, 1);
    if (w_valid && w_ready) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_word: got %h want none", w_data);
      end else begin
        chk("rd_word", {w_last, w_data}, rq.pop_front());
      end
      acc_cnt++;
    end
    stall_q = w_valid && !w_ready;
    held    = {w_valid, w_last, w_data};
  end

  task automatic push_reads(input logic [15:0] last_word);
    for (int k = 1; k <= 28; k++)
      rq.push_back({k == 28, (k == 28) ? last_word : 16'(k)});
  endtask

  task automatic do_load(input logic [15:0] last_word);
    logic [15:0] d;
    load_start = 1'b1;
    fetch_start = 1'b1;
    tick;
    load_start = 1'b0;
    fetch_start = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      chk("load_ready", load_ready, 1);
      d = (k == 28) ? last_word : 16'(k);
      load_valid = 1'b1;
      load_data = d;
      wq.push_back({5'(k - 1), d});
      fetch_start = (k == 5);
      tick;
    end
    load_valid = 1'b0;
    fetch_start = 1'b0;
    #1;
    chk("load_done", done, 1);
    chk("load_done_busy", busy, 1);
    chk("load_done_en", bram_en, 0);
    tick;
    chk("load_end_busy", busy, 0);
    chk("load_end_done", done, 0);
    chk("load_wq_empty", wq.size(), 0);
  endtask

  task automatic do_fetch_fast(input logic [15:0] last_word);
    w_ready = 1'b1;
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    push_reads(last_word);
    chk("fetch_fill", w_valid, 0);
    tick;
    for (int i = 0; i < 28; i++) begin
      chk("fetch_stream_vld", w_valid, 1);
      chk("fetch_last_flag", w_last, i == 27);
      tick;
    end
    chk("fetch_done", done, 1);
    chk("fetch_done_vld", w_valid, 0);
    chk("fetch_acc", acc_cnt, 28);
    tick;
    chk("fetch_idle", busy, 0);
    chk("fetch_rq_empty", rq.size(), 0);
    w_ready = 1'b0;
  endtask

  task automatic do_fetch_toggle;
    logic seen;
    seen = 1'b0;
    w_ready = 1'b1;
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    push_reads(16'd28);
    for (int c = 0; c < 300 && !seen; c++) begin
      w_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick;
      if (done) seen = 1'b1;
    end
    chk("toggle_done", seen, 1);
    chk("toggle_acc", acc_cnt, 28);
    chk("toggle_rq_empty", rq.size(), 0);
    w_ready = 1'b0;
    tick;
    chk("toggle_idle", busy, 0);
  endtask

  task automatic do_reset_mid;
    w_ready = 1'b1;
    fetch_start = 1'b1;
    tick;
    fetch_start = 1'b0;
    push_reads(16'd28);
    for (int c = 0; c < 100 && acc_cnt < 10; c++) tick;
    chk("rst_wait", acc_cnt, 10);
    RST = 1'b1;
    rq.delete();
    #1;
    chk("rst_mid_outs", outs, 0);
    tick;
    RST = 1'b0;
    #1;
    chk("rst_after_outs", outs, 0);
    w_ready = 1'b0;
    tick;
    chk("rst_after_idle", busy, 0);
  endtask

  initial begin
    RST = 1'b1;
    load_start = 1'b0;
    fetch_start = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    w_ready = 1'b0;
    tick;
    tick;
    chk("rst_outs", outs, 0);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data = 16'h1234;
    #1;
    chk("rst_outs_inputs_active", outs, 0);
    tick;
    RST = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    tick;
    chk("idle_after_rst", busy, 0);

    do_load(16'd28);
    do_fetch_fast(16'd28);
    do_fetch_toggle;
    do_reset_mid;
    do_fetch_fast(16'd28);
    do_load(16'h8000);
    do_fetch_fast(16'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
